sync_fifo: RTL and testbench

//  Single-clock FIFO buffer. It is the device under test for the existing

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_mem.sv | 42 ++++
 rtl/sync_fifo.sv | 85 ++++++++
 tb/tb_sync_fifo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the single-clock FIFO and its storage array.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  // Number of entries for a given pointer width.
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: synchronous write port, registered read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write port.
  // NOTE: the array has no reset so it maps onto plain flops/RAM; stale
  // contents are never observable because count gates every read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its last value when no read is requested.
  // NOTE: non-blocking assignment here means a same-edge write to the read
  // address returns the old word, which is what the FIFO ordering needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, count-based full/empty flags
// and one-cycle overflow/underflow error pulses.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  // Count value meaning "every entry occupied".
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_accept;
  logic                  rd_accept;

  // Requests are qualified by the registered (pre-edge) flags only.
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Next occupancy: simultaneous accepted push and pop cancel out.
  // NOTE: the default is assigned first so every path drives count_next and
  // no latch is inferred.
  always_comb begin
    count_next = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy, flags and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      full       <= (count_next == FULL_COUNT);
      empty      <= (count_next == '0);
      data_valid <= rd_accept;
      overflow   <= wr_en && full;
      underflow  <= rd_en && empty;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_accept),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus randomized
// traffic, compared against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int tests;
  int fails;

  // Reference model state.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_data;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock of traffic: drive at the falling edge, advance the model using
  // the pre-edge occupancy, sample every output 1 ns after the rising edge.
  task automatic do_cycle(input string tag, input bit wr, input logic [DW-1:0] din, input bit rd);
    bit was_full, was_empty, exp_ovf, exp_udf, exp_valid;
    @(negedge clk);
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    exp_ovf   = wr && was_full;
    exp_udf   = rd && was_empty;
    exp_valid = rd && !was_empty;
    if (exp_valid) exp_data = model_q.pop_front();
    if (wr && !was_full) model_q.push_back(din);
    @(posedge clk);
    #1;
    check({tag, ".data_out"},   32'(data_out),   32'(exp_data));
    check({tag, ".data_valid"}, 32'(data_valid), 32'(exp_valid));
    check({tag, ".count"},      32'(count),      32'(model_q.size()));
    check({tag, ".full"},       32'(full),       32'(model_q.size() == DEPTH));
    check({tag, ".empty"},      32'(empty),      32'(model_q.size() == 0));
    check({tag, ".overflow"},   32'(overflow),   32'(exp_ovf));
    check({tag, ".underflow"},  32'(underflow),  32'(exp_udf));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".count"},      32'(count),      32'd0);
    check({tag, ".empty"},      32'(empty),      32'd1);
    check({tag, ".full"},       32'(full),       32'd0);
    check({tag, ".data_out"},   32'(data_out),   32'd0);
    check({tag, ".data_valid"}, 32'(data_valid), 32'd0);
    check({tag, ".overflow"},   32'(overflow),   32'd0);
    check({tag, ".underflow"},  32'(underflow),  32'd0);
  endtask

  initial begin
    int wr_bias;
    int rd_bias;
    tests    = 0;
    fails    = 0;
    exp_data = '0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    data_in  = '0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Overflow: ten writes into an eight-entry FIFO.
    for (int i = 0; i < 10; i++) do_cycle("ovf_fill", 1'b1, DW'(i), 1'b0);
    check("ovf_fill.final_count", 32'(count), 32'd8);

    // Underflow: ten reads; last two ignored, data_out stays 7.
    for (int i = 0; i < 10; i++) do_cycle("udf_drain", 1'b0, '0, 1'b1);
    check("udf_drain.last_data", 32'(data_out), 32'd7);

    // Simultaneous push/pop at count 4, crossing the pointer wrap.
    for (int i = 0; i < 4; i++) do_cycle("sim_fill", 1'b1, DW'(8'h40 + i), 1'b0);
    for (int i = 0; i < 6; i++) do_cycle("sim_both", 1'b1, DW'(8'h50 + i), 1'b1);
    check("sim_both.count_kept", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) do_cycle("sim_drain", 1'b0, '0, 1'b1);

    // Boundary: full with both requests -> read happens, write dropped.
    for (int i = 0; i < DEPTH; i++) do_cycle("bnd_fill", 1'b1, DW'(8'hA0 + i), 1'b0);
    do_cycle("bnd_full_both", 1'b1, 8'hEE, 1'b1);
    check("bnd_full_both.ovf", 32'(overflow), 32'd1);
    while (model_q.size() > 0) do_cycle("bnd_drain", 1'b0, '0, 1'b1);

    // Boundary: empty with both requests -> write happens, read ignored.
    do_cycle("bnd_empty_both", 1'b1, 8'h5A, 1'b1);
    check("bnd_empty_both.count", 32'(count), 32'd1);
    do_cycle("bnd_empty_pop", 1'b0, '0, 1'b1);
    check("bnd_empty_pop.data", 32'(data_out), 32'h5A);

    // Asynchronous reset between edges with five words stored.
    for (int i = 0; i < 5; i++) do_cycle("mid_fill", 1'b1, DW'(8'hC0 + i), 1'b0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    model_q.delete();
    exp_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle("post_rst_read", 1'b0, '0, 1'b1);

    // Randomized traffic, with the write/read bias re-drawn every 40 cycles
    // so the FIFO repeatedly reaches both full and empty.
    for (int blk = 0; blk < 10; blk++) begin
      wr_bias = int'($urandom_range(10, 90));
      rd_bias = int'($urandom_range(10, 90));
      for (int i = 0; i < 40; i++) begin
        do_cycle("rand",
                 ($urandom_range(0, 99) < wr_bias),
                 DW'($urandom),
                 ($urandom_range(0, 99) < rd_bias));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sync_fifo
